csr_irq_unit: RTL and testbench
===============================

Name: csr_irq_unit

Overview:
Parametrised machine-mode CSR and interrupt controller for the RV32 datapath. Generalises the single-line CSR unit to NUM_IRQ external interrupt lines with fixed priority, full CSRRW/CSRRS/CSRRC semantics, and mstatus MIE/MPIE save/restore on trap and mret. Adds NUM_HPM event counters with per-counter inhibit. Sits beside the decode/execute stage and drives the fetch-redirect mux.

Parameters:
XLEN, 32, data width of CSRs and PC
NUM_IRQ, 4, external interrupt lines, mapped to mip/mie bits 16..16+NUM_IRQ-1 (1..16)
NUM_HPM, 2, event counters mhpmcounter3..3+NUM_HPM-1 (0..29)
SYNC_STAGES, 2, irq synchroniser depth (>=2)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous, active-low reset
pc  in  XLEN  PC of the instruction in execute
csr_addr  in  12  CSR address
csr_wdata  in  XLEN  write operand (rs1 or zimm)
csr_op  in  2  00 none, 01 write, 10 set, 11 clear
csr_rd_en  in  1  read request
csr_rdata  out  XLEN  read data (combinational, pre-write value)
csr_illegal  out  1  access to an unimplemented address
mret  in  1  mret in execute
irq  in  NUM_IRQ  asynchronous level interrupt lines
hpm_event  in  NUM_HPM  one-cycle event pulses
instret  in  1  instruction-retire pulse
redirect  out  1  one-cycle fetch redirect
redirect_pc  out  XLEN  redirect target

Behaviour:
- Reset: all CSRs 0, FSM RUN, redirect=0, redirect_pc=0, synchronisers 0.
- CSRs: mstatus 0x300 (only bits 3 MIE and 7 MPIE writable; others read 0), mie 0x304, mtvec 0x305, mcountinhibit 0x320, mepc 0x341 (bits[1:0] forced 0), mcause 0x342, mip 0x344 (read-only; writes ignored), mcycle/mcycleh 0xB00/0xB80, minstret/minstreth 0xB02/0xB82, mhpmcounterN/Nh 0xB00+N/0xB80+N.
- Write value: op 01 -> wdata; 10 -> old|wdata; 11 -> old&~wdata; takes effect on the next edge. Any unlisted address with rd_en or op!=00 -> csr_illegal=1, no state change.
- Unimplemented mie/mip bits read 0.
- mip[16+i] = irq[i] after SYNC_STAGES flops.
- Counters: 64-bit each. Bit 0 (mcycle), bit 2 (minstret), bit N (hpmN) of mcountinhibit freeze the counter. Writing a low or high half replaces only that half, and the write wins over an increment in the same cycle. Counters wrap at 2^64 with no flag.
- FSM RUN: pending = mip & mie.
  - If mstatus.MIE=1 and pending!=0 and mret=0, take the lowest-index pending line i: mepc<=pc, mcause<={1'b1, (16+i)}, MPIE<=MIE, MIE<=0, then go to REDIRECT.
  - If mret=1: MIE<=MPIE, MPIE<=1, then go to REDIRECT.
- FSM REDIRECT: redirect=1 for exactly one cycle, then return to RUN. No new interrupt is accepted in REDIRECT.
  - Trap target: {mtvec[XLEN-1:2],2'b00}.
  - mret target: the mepc value.
- Simultaneous events:
  - mret and interrupt in the same cycle: mret wins; the interrupt is re-evaluated in RUN after the redirect.
  - CSR write and trap entry in the same cycle: trap updates to mstatus/mepc/mcause override the write; writes to other CSRs complete.
- Reset mid-REDIRECT: immediate return to RUN with redirect=0.

Optional Feature:
CSR_VECTORED_EN.
- Defined: mtvec[1:0]=01 selects vectored mode; interrupt target = {mtvec[XLEN-1:2],2'b00} + 4*(16+i); mtvec[1:0] reads back as written (00/01; 1x stored as 00).
- Undefined: mtvec[1:0] hardwired 00 and every trap goes to the base address.

Test Plan:
- Reset release, read 0x300/0xB00 -> 0 and 0; after 10 cycles, mcycle reads 10 ±1.
- mtvec=0x100, mie=0x10000, mstatus=0x8, pc=0x40, irq[0] high -> after SYNC_STAGES+1 cycles redirect=1, redirect_pc=0x100, mepc=0x40, mcause=0x80000010, mstatus=0x80.
- In the handler, mret -> redirect_pc=0x40, mstatus=0x88; irq still high -> retrap on the second cycle after the redirect.
- irq[1] and irq[3] high together with both enabled -> mcause=0x80000011. With CSR_VECTORED_EN and mtvec=0x101 -> redirect_pc=0x144.
- Write mcountinhibit=0x4 -> minstret holds across 5 instret pulses. Writing 0xFFFFFFFF to minstret then one pulse after clearing the inhibit -> minstret=0, minstreth=1.
- CSRRC 0x300 with wdata=0x8 issued in the same cycle as an mret -> mret completes, MIE=0, no trap. An access to 0x7C0 -> csr_illegal=1 with no state change.

Source files
------------

// File: rtl/csr_irq_unit.sv
`default_nettype none
// ============================================================================
// Module  : csr_irq_unit
// Machine-mode CSR file with fixed-priority interrupt entry, mret and counters.
// Optional: define CSR_VECTORED_EN to enable vectored mtvec mode.
// Revision: 1.0
// ============================================================================

module csr_irq_unit #(
   parameter int XLEN        = 32,
   parameter int NUM_IRQ     = 4,
   parameter int NUM_HPM     = 2,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [XLEN-1:0]   pc,
   input  logic [11:0]       csr_addr,
   input  logic [XLEN-1:0]   csr_wdata,
   input  logic [1:0]        csr_op,
   input  logic              csr_rd_en,
   output logic [XLEN-1:0]   csr_rdata,
   output logic              csr_illegal,
   input  logic              mret,
   input  logic [NUM_IRQ-1:0] irq,
   input  logic [NUM_HPM-1:0] hpm_event,
   input  logic              instret,
   output logic              redirect,
   output logic [XLEN-1:0]   redirect_pc
);

   localparam int NUM_CNT  = NUM_HPM + 2;
   localparam int IRQ_BASE = 16;

   localparam logic [0:0] ST_RUN      = 1'b0;
   localparam logic [0:0] ST_REDIRECT = 1'b1;

   localparam logic [1:0] OP_NONE = 2'b00;
   localparam logic [1:0] OP_SET  = 2'b10;
   localparam logic [1:0] OP_CLR  = 2'b11;

   // Implemented inhibit bits: CY (0), IR (2) and one per event counter from bit 3.
   localparam logic [XLEN-1:0] INH_MASK =
      ((((XLEN)'(1) << NUM_HPM) - (XLEN)'(1)) << 3) | (XLEN)'(5);

   function automatic logic [XLEN-1:0] csr_apply(input logic [XLEN-1:0] old_v,
                                                 input logic [XLEN-1:0] wd,
                                                 input logic [1:0]      op);
      case (op)
         OP_SET:  csr_apply = old_v | wd;
         OP_CLR:  csr_apply = old_v & ~wd;
         default: csr_apply = wd;
      endcase
   endfunction

   // Counter k maps to CSR number 0 (mcycle), 2 (minstret), k+1 (mhpmcounter).
   function automatic logic [4:0] cnt_num(input int k);
      if (k == 0)      cnt_num = 5'd0;
      else if (k == 1) cnt_num = 5'd2;
      else             cnt_num = 5'(k + 1);
   endfunction

   logic [0:0]         state_q, state_d;
   logic               mstatus_mie_q, mstatus_mie_d;
   logic               mstatus_mpie_q, mstatus_mpie_d;
   logic [NUM_IRQ-1:0] mie_q, mie_d;
   logic [XLEN-1:0]    mtvec_q, mtvec_d;
   logic [XLEN-1:0]    mcountinhibit_q, mcountinhibit_d;
   logic [XLEN-1:0]    mepc_q, mepc_d;
   logic [XLEN-1:0]    mcause_q, mcause_d;
   logic [XLEN-1:0]    redirect_pc_q, redirect_pc_d;
   logic [63:0]        cnt_q [NUM_CNT];
   logic [63:0]        cnt_d [NUM_CNT];
   logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
   logic [NUM_IRQ-1:0] sync_d [SYNC_STAGES];

   logic [XLEN-1:0]    mstatus_rd, mie_rd, mip_rd;
   logic [XLEN-1:0]    wval, mstatus_nx, mtvec_wr, trap_target;
   logic               known, cnt_addr, wr_en;
   logic [NUM_IRQ-1:0] pending;
   logic               irq_found;
   logic [4:0]         irq_idx;
   logic               take_trap, take_mret;
   logic [NUM_CNT-1:0] cnt_inc, cnt_inh;

   assign mstatus_rd = ((XLEN)'(mstatus_mpie_q) << 7) | ((XLEN)'(mstatus_mie_q) << 3);
   assign mie_rd     = (XLEN)'(mie_q) << IRQ_BASE;
   assign mip_rd     = (XLEN)'(sync_q[SYNC_STAGES-1]) << IRQ_BASE;
   assign cnt_addr   = (csr_addr[11:8] == 4'hB) && (csr_addr[6:5] == 2'b00);
   assign cnt_inc    = {hpm_event, instret, 1'b1};
   assign cnt_inh    = {mcountinhibit_q[3 +: NUM_HPM], mcountinhibit_q[2], mcountinhibit_q[0]};

   always_comb begin
      csr_rdata = '0;
      known     = 1'b1;
      case (csr_addr)
         12'h300: csr_rdata = mstatus_rd;
         12'h304: csr_rdata = mie_rd;
         12'h305: csr_rdata = mtvec_q;
         12'h320: csr_rdata = mcountinhibit_q;
         12'h341: csr_rdata = mepc_q;
         12'h342: csr_rdata = mcause_q;
         12'h344: csr_rdata = mip_rd;
         default: begin
            known = 1'b0;
            for (int k = 0; k < NUM_CNT; k++) begin
               if (cnt_addr && (csr_addr[4:0] == cnt_num(k))) begin
                  known     = 1'b1;
                  csr_rdata = csr_addr[7] ? (XLEN)'(cnt_q[k][63:32]) : (XLEN)'(cnt_q[k][31:0]);
               end
            end
         end
      endcase
   end

   assign csr_illegal = (csr_rd_en || (csr_op != OP_NONE)) && !known;
   assign wr_en       = (csr_op != OP_NONE) && known;
   assign wval        = csr_apply(csr_rdata, csr_wdata, csr_op);

   assign pending = mie_q & sync_q[SYNC_STAGES-1];

   // Scan downwards so the lowest pending line is the one left selected.
   always_comb begin
      irq_found = 1'b0;
      irq_idx   = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (pending[i]) begin
            irq_found = 1'b1;
            irq_idx   = 5'(IRQ_BASE + i);
         end
      end
   end

   assign take_mret = (state_q == ST_RUN) && mret;
   assign take_trap = (state_q == ST_RUN) && !mret && mstatus_mie_q && irq_found;

   always_comb begin
`ifdef CSR_VECTORED_EN
      mtvec_wr = {wval[XLEN-1:2], (wval[1:0] == 2'b01) ? 2'b01 : 2'b00};
      if (mtvec_q[1:0] == 2'b01)
         trap_target = {mtvec_q[XLEN-1:2], 2'b00} + ((XLEN)'(irq_idx) << 2);
      else
         trap_target = {mtvec_q[XLEN-1:2], 2'b00};
`else
      mtvec_wr    = {wval[XLEN-1:2], 2'b00};
      trap_target = {mtvec_q[XLEN-1:2], 2'b00};
`endif
   end

   always_comb begin
      sync_d[0] = irq;
      for (int s = 1; s < SYNC_STAGES; s++) sync_d[s] = sync_q[s-1];

      mie_d           = mie_q;
      mtvec_d         = mtvec_q;
      mcountinhibit_d = mcountinhibit_q;
      mepc_d          = mepc_q;
      mcause_d        = mcause_q;
      redirect_pc_d   = redirect_pc_q;

      // A same-cycle mstatus write is applied on top of the mret update.
      mstatus_nx = take_mret ? (((XLEN)'(1) << 7) | ((XLEN)'(mstatus_mpie_q) << 3)) : mstatus_rd;
      if (wr_en && (csr_addr == 12'h300)) mstatus_nx = csr_apply(mstatus_nx, csr_wdata, csr_op);
      mstatus_mie_d  = mstatus_nx[3];
      mstatus_mpie_d = mstatus_nx[7];

      if (wr_en) begin
         case (csr_addr)
            12'h304: mie_d           = wval[IRQ_BASE +: NUM_IRQ];
            12'h305: mtvec_d         = mtvec_wr;
            12'h320: mcountinhibit_d = wval & INH_MASK;
            12'h341: mepc_d          = wval & ~(XLEN)'(3);
            12'h342: mcause_d        = wval;
            default: ;
         endcase
      end

      if (take_trap) begin
         mepc_d         = pc & ~(XLEN)'(3);
         mcause_d       = {1'b1, (XLEN-1)'(irq_idx)};
         mstatus_mpie_d = mstatus_mie_q;
         mstatus_mie_d  = 1'b0;
         redirect_pc_d  = trap_target;
      end else if (take_mret) begin
         redirect_pc_d  = mepc_q;
      end

      for (int k = 0; k < NUM_CNT; k++) begin
         cnt_d[k] = cnt_q[k];
         if (wr_en && cnt_addr && (csr_addr[4:0] == cnt_num(k))) begin
            if (csr_addr[7]) cnt_d[k][63:32] = wval[31:0];
            else             cnt_d[k][31:0]  = wval[31:0];
         end else if (cnt_inc[k] && !cnt_inh[k]) begin
            cnt_d[k] = cnt_q[k] + 64'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mstatus_mie_q   <= 1'b0;
         mstatus_mpie_q  <= 1'b0;
         mie_q           <= '0;
         mtvec_q         <= '0;
         mcountinhibit_q <= '0;
         mepc_q          <= '0;
         mcause_q        <= '0;
         redirect_pc_q   <= '0;
         for (int k = 0; k < NUM_CNT; k++) cnt_q[k] <= '0;
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      end else begin
         mstatus_mie_q   <= mstatus_mie_d;
         mstatus_mpie_q  <= mstatus_mpie_d;
         mie_q           <= mie_d;
         mtvec_q         <= mtvec_d;
         mcountinhibit_q <= mcountinhibit_d;
         mepc_q          <= mepc_d;
         mcause_q        <= mcause_d;
         redirect_pc_q   <= redirect_pc_d;
         for (int k = 0; k < NUM_CNT; k++) cnt_q[k] <= cnt_d[k];
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= sync_d[s];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= ST_RUN;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN:      if (take_trap || take_mret) state_d = ST_REDIRECT;
         ST_REDIRECT: state_d = ST_RUN;
         default:     state_d = ST_RUN;
      endcase
   end

   always_comb begin
      redirect    = (state_q == ST_REDIRECT);
      redirect_pc = redirect_pc_q;
   end

endmodule

`default_nettype wire

// File: tb/tb_csr_irq_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_csr_irq_unit
// Directed self-checking bench for csr_irq_unit.
// Revision: 1.0
// ============================================================================

module tb_csr_irq_unit;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] pc;
   logic [11:0] csr_addr;
   logic [31:0] csr_wdata;
   logic [1:0]  csr_op;
   logic        csr_rd_en;
   logic [31:0] csr_rdata;
   logic        csr_illegal;
   logic        mret;
   logic [3:0]  irq;
   logic [1:0]  hpm_event;
   logic        instret;
   logic        redirect;
   logic [31:0] redirect_pc;

   int errors = 0;
   int checks = 0;
   logic [31:0] rd;

`ifdef CSR_VECTORED_EN
   localparam logic [31:0] EXP_MTVEC = 32'h101;
   localparam logic [31:0] EXP_PRIO_PC = 32'h144;
`else
   localparam logic [31:0] EXP_MTVEC = 32'h100;
   localparam logic [31:0] EXP_PRIO_PC = 32'h100;
`endif

   always #10 clk = ~clk;

   csr_irq_unit dut (
      .clk(clk), .reset_n(reset_n), .pc(pc), .csr_addr(csr_addr),
      .csr_wdata(csr_wdata), .csr_op(csr_op), .csr_rd_en(csr_rd_en),
      .csr_rdata(csr_rdata), .csr_illegal(csr_illegal), .mret(mret),
      .irq(irq), .hpm_event(hpm_event), .instret(instret),
      .redirect(redirect), .redirect_pc(redirect_pc)
   );

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic csr_rd(input logic [11:0] a, output logic [31:0] d);
      csr_addr = a; csr_rd_en = 1'b1; #1; d = csr_rdata; csr_rd_en = 1'b0;
   endtask

   task automatic csr_wr(input logic [11:0] a, input logic [31:0] d, input logic [1:0] op);
      csr_addr = a; csr_wdata = d; csr_op = op; tick(); csr_op = 2'b00;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; pc = '0; csr_addr = '0; csr_wdata = '0; csr_op = '0;
      csr_rd_en = 1'b0; mret = 1'b0; irq = '0; hpm_event = '0; instret = 1'b0;
      repeat (3) tick();
      checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL reset_redirect: got %b want 0", redirect); end
      checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL reset_redirect_pc: got %h want 0", redirect_pc); end
      reset_n = 1'b1;
      csr_rd(12'h300, rd);
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_mstatus: got %h want 0", rd); end
      csr_rd(12'hB00, rd);
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_mcycle: got %h want 0", rd); end
      repeat (10) tick();
      csr_rd(12'hB00, rd);
      checks++; if (rd < 32'd9 || rd > 32'd11) begin errors++; $display("FAIL mcycle_10: got %0d want 10 +-1", rd); end
   endtask

   task automatic test_trap();
      csr_wr(12'h305, 32'h100, 2'b01);
      csr_wr(12'h304, 32'h10000, 2'b01);
      csr_wr(12'h300, 32'h8, 2'b01);
      pc = 32'h40;
      irq = 4'b0001;
      repeat (2) tick();
      checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL trap_early: got %b want 0", redirect); end
      tick();
      checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL trap_redirect: got %b want 1", redirect); end
      checks++; if (redirect_pc !== 32'h100) begin errors++; $display("FAIL trap_pc: got %h want 100", redirect_pc); end
      csr_rd(12'h341, rd);
      checks++; if (rd !== 32'h40) begin errors++; $display("FAIL trap_mepc: got %h want 40", rd); end
      csr_rd(12'h342, rd);
      checks++; if (rd !== 32'h80000010) begin errors++; $display("FAIL trap_mcause: got %h want 80000010", rd); end
      csr_rd(12'h300, rd);
      checks++; if (rd !== 32'h80) begin errors++; $display("FAIL trap_mstatus: got %h want 80", rd); end
      tick();
      checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL trap_one_cycle: got %b want 0", redirect); end
   endtask

   task automatic test_mret();
      mret = 1'b1; tick(); mret = 1'b0;
      checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL mret_redirect: got %b want 1", redirect); end
      checks++; if (redirect_pc !== 32'h40) begin errors++; $display("FAIL mret_pc: got %h want 40", redirect_pc); end
      csr_rd(12'h300, rd);
      checks++; if (rd !== 32'h88) begin errors++; $display("FAIL mret_mstatus: got %h want 88", rd); end
      tick();
      checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL mret_gap: got %b want 0", redirect); end
      tick();
      checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL retrap_redirect: got %b want 1", redirect); end
      checks++; if (redirect_pc !== 32'h100) begin errors++; $display("FAIL retrap_pc: got %h want 100", redirect_pc); end
      irq = 4'b0000;
      tick();
   endtask

   task automatic test_priority();
      csr_wr(12'h304, 32'hA0000, 2'b01);
      irq = 4'b1010;
      pc = 32'h80;
      csr_wr(12'h305, 32'h101, 2'b01);
      csr_rd(12'h305, rd);
      checks++; if (rd !== EXP_MTVEC) begin errors++; $display("FAIL mtvec_mode: got %h want %h", rd, EXP_MTVEC); end
      repeat (2) tick();
      csr_wr(12'h300, 32'h8, 2'b10);
      checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL prio_early: got %b want 0", redirect); end
      tick();
      checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL prio_redirect: got %b want 1", redirect); end
      checks++; if (redirect_pc !== EXP_PRIO_PC) begin errors++; $display("FAIL prio_pc: got %h want %h", redirect_pc, EXP_PRIO_PC); end
      csr_rd(12'h342, rd);
      checks++; if (rd !== 32'h80000011) begin errors++; $display("FAIL prio_mcause: got %h want 80000011", rd); end
      tick();
   endtask

   task automatic test_mret_clear();
      int seen;
      mret = 1'b1; csr_addr = 12'h300; csr_wdata = 32'h8; csr_op = 2'b11;
      tick();
      mret = 1'b0; csr_op = 2'b00;
      checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL mretclr_redirect: got %b want 1", redirect); end
      checks++; if (redirect_pc !== 32'h80) begin errors++; $display("FAIL mretclr_pc: got %h want 80", redirect_pc); end
      csr_rd(12'h300, rd);
      checks++; if (rd !== 32'h80) begin errors++; $display("FAIL mretclr_mstatus: got %h want 80", rd); end
      seen = 0;
      for (int c = 0; c < 4; c++) begin tick(); if (redirect) seen++; end
      checks++; if (seen !== 0) begin errors++; $display("FAIL mretclr_no_trap: got %0d redirects want 0", seen); end
      irq = 4'b0000;
   endtask

   task automatic test_csr_ops();
      csr_wr(12'h342, 32'hF0, 2'b01);
      csr_wr(12'h342, 32'h0F, 2'b10);
      csr_rd(12'h342, rd);
      checks++; if (rd !== 32'hFF) begin errors++; $display("FAIL csrrs: got %h want ff", rd); end
      csr_wr(12'h342, 32'h3C, 2'b11);
      csr_rd(12'h342, rd);
      checks++; if (rd !== 32'hC3) begin errors++; $display("FAIL csrrc: got %h want c3", rd); end
      csr_wr(12'h341, 32'h1237, 2'b01);
      csr_rd(12'h341, rd);
      checks++; if (rd !== 32'h1234) begin errors++; $display("FAIL mepc_align: got %h want 1234", rd); end
      csr_wr(12'h300, 32'hFFFFFF77, 2'b01);
      csr_rd(12'h300, rd);
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL mstatus_mask: got %h want 0", rd); end
      irq = 4'b0100;
      repeat (2) tick();
      csr_wr(12'h344, 32'hFFFFFFFF, 2'b01);
      csr_rd(12'h344, rd);
      checks++; if (rd !== 32'h40000) begin errors++; $display("FAIL mip_ro: got %h want 40000", rd); end
      irq = 4'b0000;
   endtask

   task automatic test_illegal();
      csr_addr = 12'h7C0; csr_wdata = 32'hFFFFFFFF; csr_op = 2'b01; #1;
      checks++; if (csr_illegal !== 1'b1) begin errors++; $display("FAIL illegal_7c0: got %b want 1", csr_illegal); end
      tick(); csr_op = 2'b00;
      csr_rd(12'h305, rd);
      checks++; if (rd !== EXP_MTVEC) begin errors++; $display("FAIL illegal_mtvec: got %h want %h", rd, EXP_MTVEC); end
      csr_rd(12'h342, rd);
      checks++; if (rd !== 32'hC3) begin errors++; $display("FAIL illegal_mcause: got %h want c3", rd); end
      csr_addr = 12'hB01; csr_rd_en = 1'b1; #1;
      checks++; if (csr_illegal !== 1'b1) begin errors++; $display("FAIL illegal_b01: got %b want 1", csr_illegal); end
      csr_addr = 12'hB83; #1;
      checks++; if (csr_illegal !== 1'b0) begin errors++; $display("FAIL legal_b83: got %b want 0", csr_illegal); end
      csr_rd_en = 1'b0;
   endtask

   task automatic test_counters();
      csr_wr(12'h320, 32'h4, 2'b01);
      csr_rd(12'h320, rd);
      checks++; if (rd !== 32'h4) begin errors++; $display("FAIL inhibit_rd: got %h want 4", rd); end
      instret = 1'b1; repeat (5) tick(); instret = 1'b0;
      csr_rd(12'hB02, rd);
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL minstret_hold: got %h want 0", rd); end
      csr_wr(12'hB02, 32'hFFFFFFFF, 2'b01);
      csr_wr(12'h320, 32'h0, 2'b01);
      instret = 1'b1; tick(); instret = 1'b0;
      csr_rd(12'hB02, rd);
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL minstret_wrap_lo: got %h want 0", rd); end
      csr_rd(12'hB82, rd);
      checks++; if (rd !== 32'h1) begin errors++; $display("FAIL minstret_wrap_hi: got %h want 1", rd); end
      hpm_event = 2'b01; repeat (3) tick(); hpm_event = 2'b00;
      csr_rd(12'hB03, rd);
      checks++; if (rd !== 32'h3) begin errors++; $display("FAIL hpm3_count: got %h want 3", rd); end
      hpm_event = 2'b01; csr_wr(12'hB03, 32'h50, 2'b01); hpm_event = 2'b00;
      csr_rd(12'hB03, rd);
      checks++; if (rd !== 32'h50) begin errors++; $display("FAIL hpm3_write_wins: got %h want 50", rd); end
      hpm_event = 2'b10; repeat (2) tick(); hpm_event = 2'b00;
      csr_rd(12'hB04, rd);
      checks++; if (rd !== 32'h2) begin errors++; $display("FAIL hpm4_count: got %h want 2", rd); end
      csr_rd(12'hB03, rd);
      checks++; if (rd !== 32'h50) begin errors++; $display("FAIL hpm3_isolated: got %h want 50", rd); end
   endtask

   task automatic test_reset_mid_redirect();
      csr_wr(12'h305, 32'h200, 2'b01);
      csr_wr(12'h304, 32'h10000, 2'b01);
      csr_wr(12'h300, 32'h8, 2'b01);
      irq = 4'b0001;
      repeat (3) tick();
      checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL rstmid_redirect: got %b want 1", redirect); end
      checks++; if (redirect_pc !== 32'h200) begin errors++; $display("FAIL rstmid_pc: got %h want 200", redirect_pc); end
      reset_n = 1'b0; #1;
      checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL rstmid_clear: got %b want 0", redirect); end
      checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL rstmid_pc_clear: got %h want 0", redirect_pc); end
      csr_rd(12'h344, rd);
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rstmid_sync: got %h want 0", rd); end
      irq = 4'b0000;
      tick();
      reset_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_trap();
      test_mret();
      test_priority();
      test_mret_clear();
      test_csr_ops();
      test_illegal();
      test_counters();
      test_reset_mid_redirect();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
